// File: rtl/weight_buffer_loader.sv
// Converts a DDR weight beat stream into weight-buffer writes. Each accepted beat fills one
// group of banks at the current address; groups sweep 0..GROUPS-1, then the address advances.
module weight_buffer_loader #(
  parameter int X_PE           = 16,
  parameter int X_MESH         = 16,
  parameter int ADDR_LEN       = 16,
  parameter int DATA_LEN       = 64,
  parameter int DDR_DATA_LEN   = 256,
  parameter int BUFFER_NUM     = 8 * X_PE * X_MESH / DATA_LEN,
  parameter int BANKS_PER_BEAT = DDR_DATA_LEN / DATA_LEN,
  parameter int GROUPS         = BUFFER_NUM / BANKS_PER_BEAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic [ADDR_LEN-1:0]     load_base_addr,
  input  logic [ADDR_LEN:0]       load_rows,
  input  logic                    load_abort,
  input  logic [DDR_DATA_LEN-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DDR_DATA_LEN-1:0] data_wr,
  output logic [ADDR_LEN-1:0]     wr_addr,
  output logic [BUFFER_NUM-1:0]   wr_en,
  output logic                    busy,
  output logic                    load_done
);

  localparam int GRP_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [BUFFER_NUM-1:0] GRP_MASK = BUFFER_NUM'((1 << BANKS_PER_BEAT) - 1);
  localparam logic [GRP_W-1:0]      GRP_LAST = GRP_W'(GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Exposed for debug and assertion binding.
  state_e              state;
  logic [GRP_W-1:0]    grp;
  logic [ADDR_LEN-1:0] cur_addr;
  logic [ADDR_LEN:0]   rows_left;

  // Handshake: a beat transfers at a posedge where s_valid && s_ready, except in a cycle where
  // load_abort is high (abort discards the presented beat). s_ready comes from registered state
  // only, so there is no combinational path from s_valid.
  assign s_ready = (state == LOAD);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grp       <= '0;
      cur_addr  <= '0;
      rows_left <= '0;
      data_wr   <= '0;
      wr_addr   <= '0;
      wr_en     <= '0;
      load_done <= 1'b0;
    end else begin
      wr_en     <= '0;
      load_done <= 1'b0;
      if (load_abort) begin
        state     <= IDLE;
        grp       <= '0;
        rows_left <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (load_start) begin
              cur_addr  <= load_base_addr;
              rows_left <= load_rows;
              grp       <= '0;
              // A zero-row load still reports exactly one done pulse.
              state     <= (load_rows != '0) ? LOAD : FINISH;
            end
          end
          LOAD: begin
            if (s_valid) begin
              data_wr <= s_data;
              wr_addr <= cur_addr;
              wr_en   <= GRP_MASK << (grp * BANKS_PER_BEAT);
              if (grp == GRP_LAST) begin
                grp       <= '0;
                cur_addr  <= cur_addr + ADDR_LEN'(1);
                rows_left <= rows_left - (ADDR_LEN + 1)'(1);
                if (rows_left == (ADDR_LEN + 1)'(1)) state <= FINISH;
              end else begin
                grp <= grp + GRP_W'(1);
              end
            end
          end
          FINISH: begin
            load_done <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Randomized bench for weight_buffer_loader: a beat-index reference model predicts every
// write, handshake and status output each cycle.
`timescale 1ns/1ps
module tb_weight_buffer_loader;

  localparam int AW = 16;
  localparam int DW = 256;
  localparam int BN = 32;
  localparam int EW = AW + BN + DW;
  localparam int CW = EW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic [AW-1:0] load_base_addr;
  logic [AW:0]   load_rows;
  logic          load_abort;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] data_wr;
  logic [AW-1:0] wr_addr;
  logic [BN-1:0] wr_en;
  logic          busy;
  logic          load_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;

  weight_buffer_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base_addr(load_base_addr),
    .load_rows(load_rows), .load_abort(load_abort), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .data_wr(data_wr), .wr_addr(wr_addr), .wr_en(wr_en), .busy(busy),
    .load_done(load_done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write port: either the predicted write for a beat taken at the last edge, or quiet/hold.
  task automatic check_wr();
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wr_addr", CW'(wr_addr), CW'(e[EW-1 -: AW]));
      check("wr_en", CW'(wr_en), CW'(e[DW +: BN]));
      check("data_wr", CW'(data_wr), CW'(e[DW-1:0]));
      last_addr = e[EW-1 -: AW];
      last_data = e[DW-1:0];
    end else begin
      check("wr_en_quiet", CW'(wr_en), CW'(0));
      check("wr_addr_hold", CW'(wr_addr), CW'(last_addr));
      check("data_wr_hold", CW'(data_wr), CW'(last_data));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_wr();
      check("idle_done", CW'(load_done), CW'(0));
      check("idle_busy", CW'(busy), CW'(0));
      check("idle_ready", CW'(s_ready), CW'(0));
    end
  endtask

  // ---------------- driver + reference model ----------------
  // Beat k of a load lands at base + k/8 (mod 2^16) on bank group k%8.
  task automatic do_load(input logic [AW-1:0] base, input int rows, input int vpct,
                         input int abort_at);
    int   total;
    int   acc;
    int   cyc;
    int   limit;
    bit   fin;
    bit   done;
    bit   aborted;
    logic [AW-1:0] a;
    logic [BN-1:0] m;
    total   = rows * 8;
    limit   = total * 40 + 20;
    acc     = 0;
    cyc     = 0;
    done    = 1'b0;
    aborted = 1'b0;
    @(negedge clk);
    load_base_addr = base;
    load_rows      = (AW + 1)'(rows);
    load_start     = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    fin = (total == 0);
    forever begin
      check_wr();
      check("load_done", CW'(load_done), CW'(done));
      check("busy", CW'(busy), CW'((acc < total && !aborted) || fin));
      check("s_ready", CW'(s_ready), CW'(acc < total && !aborted));
      if (done || aborted) break;
      if (cyc > limit) begin
        check("cycle_budget", CW'(cyc), CW'(limit));
        break;
      end
      s_valid = ($urandom_range(99) < vpct);
      for (int i = 0; i < DW / 32; i++) s_data[i*32 +: 32] = $urandom;
      load_abort = (abort_at >= 0 && acc == abort_at && acc < total);
      // Spurious starts while busy must have no effect.
      if ($urandom_range(3) == 0) begin
        load_start     = 1'b1;
        load_base_addr = AW'($urandom);
        load_rows      = (AW + 1)'($urandom_range(5));
      end
      @(posedge clk);
      done = fin;
      fin  = 1'b0;
      if (load_abort) begin
        aborted = 1'b1;
      end else if (s_valid && acc < total) begin
        a = base + AW'(acc / 8);
        m = BN'(32'hF << (4 * (acc % 8)));
        exp_q.push_back({a, m, s_data});
        acc++;
        if (acc == total) fin = 1'b1;
      end
      #1;
      load_abort = 1'b0;
      load_start = 1'b0;
      s_valid    = 1'b0;
      cyc++;
    end
    check("beats_written", CW'(acc), CW'((abort_at >= 0 && abort_at < total) ? abort_at : total));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rows;
    int ab;
    rst_n = 1'b0; load_start = 1'b0; load_base_addr = '0; load_rows = '0;
    load_abort = 1'b0; s_data = '0; s_valid = 1'b0;
    last_addr = '0; last_data = '0;
    #12;
    check("rst_wr_en", CW'(wr_en), CW'(0));
    check("rst_wr_addr", CW'(wr_addr), CW'(0));
    check("rst_data_wr", CW'(data_wr), CW'(0));
    check("rst_busy", CW'(busy), CW'(0));
    check("rst_ready", CW'(s_ready), CW'(0));
    check("rst_done", CW'(load_done), CW'(0));
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(2);

    do_load(16'h0010, 1, 100, -1);
    idle_cycles(1);
    do_load(16'h0000, 2, 50, -1);
    do_load(16'hFFFF, 2, 70, -1);
    do_load(16'h1234, 0, 100, -1);
    idle_cycles(1);
    do_load(16'h0020, 1, 100, 3);
    idle_cycles(2);
    do_load(16'h0010, 1, 100, -1);

    // Start and abort together in IDLE: abort wins.
    @(negedge clk);
    load_start = 1'b1; load_abort = 1'b1; load_rows = 17'd1;
    @(posedge clk); #1;
    load_start = 1'b0; load_abort = 1'b0;
    check("start_abort_busy", CW'(busy), CW'(0));
    idle_cycles(2);

    // Asynchronous reset in the middle of a load.
    @(negedge clk);
    load_base_addr = 16'h0100; load_rows = 17'd2; load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0; s_valid = 1'b1; s_data = {8{32'hA5A5_5A5A}};
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", CW'(wr_en), CW'(0));
    check("mid_rst_busy", CW'(busy), CW'(0));
    check("mid_rst_ready", CW'(s_ready), CW'(0));
    check("mid_rst_addr", CW'(wr_addr), CW'(0));
    check("mid_rst_data", CW'(data_wr), CW'(0));
    s_valid = 1'b0;
    last_addr = '0; last_data = '0;
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(2);
    do_load(16'h0010, 1, 100, -1);

    for (int t = 0; t < 20; t++) begin
      rows = $urandom_range(3);
      ab   = -1;
      if (rows > 0 && $urandom_range(4) == 0) ab = $urandom_range(rows * 8 - 1);
      do_load(AW'($urandom), rows, $urandom_range(100, 30), ab);
      if ($urandom_range(1) == 1) idle_cycles(1);
    end
    idle_cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
